// File: rtl/gcm_aes_decrypt.sv
// AES-GCM authenticated decryption: CTR keystream via a shared AES core,
// digit-serial GHASH and final tag compare. Plaintext is released before the verdict.
module gcm_aes_decrypt #(
  parameter int GHASH_DIGIT = 1
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [0:95]  i_iv,
  input  logic [0:127] i_tag,
  input  logic [0:63]  i_aad_size,
  input  logic [0:63]  i_ct_size,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:127] i_data,
  output logic         o_aes_req,
  output logic [0:127] o_aes_block,
  input  logic         i_aes_ack,
  input  logic [0:127] i_aes_result,
  output logic         o_pt_valid,
  output logic [0:127] o_pt,
  output logic         o_done,
  output logic         o_auth_ok
);
  localparam int           MULT_CYC = 128 / GHASH_DIGIT;
  localparam logic [0:127] R_POLY   = {8'he1, 120'd0};

  typedef enum logic [3:0] {
    IDLE, REQ_H, REQ_J0, AAD_WAIT, CT_REQ, CT_WAIT, MULT, LEN, FINAL
  } state_t;

  state_t       state, ret;
  logic [0:127] h, ej0, ks, cb, tag, x, x_op, z, v;
  logic [63:0]  aad_sz, ct_sz, aad_in, ct_in;
  logic [57:0]  aad_left, ct_left;
  logic [7:0]   cnt;
  logic [0:127] blk_mask, d_masked, z_n, v_n;

  assign aad_in  = i_aad_size;
  assign ct_in   = i_ct_size;
  assign o_ready = (state == AAD_WAIT) || (state == CT_WAIT);

  function automatic logic [57:0] blocks(input logic [63:0] s);
    return {1'b0, s[63:7]} + {57'd0, |s[6:0]};
  endfunction

  function automatic logic [0:127] inc32(input logic [0:127] b);
    return {b[0:95], b[96:127] + 32'd1};
  endfunction

  // Keep the first m bits of the block; m = 0 means a full final block.
  function automatic logic [0:127] tail_mask(input logic [6:0] m);
    logic [0:127] f;
    f = '1;
    if (m == 7'd0) return f;
    return ~(f >> m);
  endfunction

  always_comb begin
    blk_mask = '1;
    if (state == AAD_WAIT && aad_left == 58'd1)
      blk_mask = tail_mask(aad_sz[6:0]);
    else if (state == CT_WAIT && ct_left == 58'd1)
      blk_mask = tail_mask(ct_sz[6:0]);
    d_masked = i_data & blk_mask;
  end

  // GHASH_DIGIT steps of the bit-serial SP 800-38D multiply per cycle.
  always_comb begin
    z_n = z;
    v_n = v;
    for (int j = 0; j < GHASH_DIGIT; j++) begin
      if (x_op[j]) z_n = z_n ^ v_n;
      v_n = v_n[127] ? ((v_n >> 1) ^ R_POLY) : (v_n >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= IDLE;
      ret         <= IDLE;
      h           <= '0;
      ej0         <= '0;
      ks          <= '0;
      cb          <= '0;
      tag         <= '0;
      x           <= '0;
      x_op        <= '0;
      z           <= '0;
      v           <= '0;
      aad_sz      <= '0;
      ct_sz       <= '0;
      aad_left    <= '0;
      ct_left     <= '0;
      cnt         <= '0;
      o_aes_req   <= 1'b0;
      o_aes_block <= '0;
      o_pt_valid  <= 1'b0;
      o_pt        <= '0;
      o_done      <= 1'b0;
      o_auth_ok   <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_pt_valid <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          tag         <= i_tag;
          aad_sz      <= aad_in;
          ct_sz       <= ct_in;
          aad_left    <= blocks(aad_in);
          ct_left     <= blocks(ct_in);
          x           <= '0;
          cb          <= {i_iv, 32'd1};
          o_aes_block <= '0;
          o_auth_ok   <= 1'b0;
          state       <= REQ_H;
        end
        REQ_H, REQ_J0, CT_REQ: begin
          // Request goes up one cycle after entry; an ack with no request is ignored.
          if (!o_aes_req) o_aes_req <= 1'b1;
          else if (i_aes_ack) begin
            o_aes_req <= 1'b0;
            if (state == REQ_H) begin
              h           <= i_aes_result;
              o_aes_block <= cb;
              state       <= REQ_J0;
            end else if (state == REQ_J0) begin
              ej0 <= i_aes_result;
              if (aad_left != 58'd0) state <= AAD_WAIT;
              else if (ct_left != 58'd0) begin
                cb          <= inc32(cb);
                o_aes_block <= inc32(cb);
                state       <= CT_REQ;
              end else state <= LEN;
            end else begin
              ks    <= i_aes_result;
              state <= CT_WAIT;
            end
          end
        end
        AAD_WAIT: if (i_valid) begin
          x_op     <= x ^ d_masked;
          z        <= '0;
          v        <= h;
          cnt      <= '0;
          aad_left <= aad_left - 58'd1;
          ret      <= (aad_left != 58'd1) ? AAD_WAIT : ((ct_left != 58'd0) ? CT_REQ : LEN);
          state    <= MULT;
        end
        CT_WAIT: if (i_valid) begin
          o_pt       <= (i_data ^ ks) & blk_mask;
          o_pt_valid <= 1'b1;
          x_op       <= x ^ d_masked;
          z          <= '0;
          v          <= h;
          cnt        <= '0;
          ct_left    <= ct_left - 58'd1;
          ret        <= (ct_left != 58'd1) ? CT_REQ : LEN;
          state      <= MULT;
        end
        MULT: begin
          x_op <= x_op << GHASH_DIGIT;
          z    <= z_n;
          v    <= v_n;
          cnt  <= cnt + 8'd1;
          if (cnt == 8'(MULT_CYC - 1)) begin
            x     <= z_n;
            state <= ret;
            if (ret == CT_REQ) begin
              cb          <= inc32(cb);
              o_aes_block <= inc32(cb);
            end
          end
        end
        LEN: begin
          x_op  <= x ^ {aad_sz, ct_sz};
          z     <= '0;
          v     <= h;
          cnt   <= '0;
          ret   <= FINAL;
          state <= MULT;
        end
        FINAL: begin
          o_done    <= 1'b1;
          o_auth_ok <= ((x ^ ej0) == tag);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcm_aes_decrypt.sv
// Directed NIST GCM vectors against two instances (GHASH_DIGIT 1 and 8) sharing one stimulus path.
module tb_gcm_aes_decrypt;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, valid, aes_ack;
  logic [0:95]  iv;
  logic [0:127] tag, data, aes_res;
  logic [0:63]  aad_size, ct_size;
  int           sel, dmax;

  logic         ready_w[2], req_w[2], ptv_w[2], done_w[2], auth_w[2];
  logic [0:127] blk_w[2], pt_w[2];
  logic         ready_s, req_s, ptv_s, done_s, auth_s;
  logic [0:127] blk_s, pt_s;

  gcm_aes_decrypt #(.GHASH_DIGIT(1)) dut1 (
    .clk(clk), .i_reset(rst), .i_start(start && sel == 0), .i_iv(iv), .i_tag(tag),
    .i_aad_size(aad_size), .i_ct_size(ct_size), .i_valid(valid), .o_ready(ready_w[0]),
    .i_data(data), .o_aes_req(req_w[0]), .o_aes_block(blk_w[0]), .i_aes_ack(aes_ack),
    .i_aes_result(aes_res), .o_pt_valid(ptv_w[0]), .o_pt(pt_w[0]), .o_done(done_w[0]),
    .o_auth_ok(auth_w[0]));

  gcm_aes_decrypt #(.GHASH_DIGIT(8)) dut8 (
    .clk(clk), .i_reset(rst), .i_start(start && sel == 1), .i_iv(iv), .i_tag(tag),
    .i_aad_size(aad_size), .i_ct_size(ct_size), .i_valid(valid), .o_ready(ready_w[1]),
    .i_data(data), .o_aes_req(req_w[1]), .o_aes_block(blk_w[1]), .i_aes_ack(aes_ack),
    .i_aes_result(aes_res), .o_pt_valid(ptv_w[1]), .o_pt(pt_w[1]), .o_done(done_w[1]),
    .o_auth_ok(auth_w[1]));

  assign ready_s = ready_w[sel];
  assign req_s   = req_w[sel];
  assign ptv_s   = ptv_w[sel];
  assign done_s  = done_w[sel];
  assign auth_s  = auth_w[sel];
  assign blk_s   = blk_w[sel];
  assign pt_s    = pt_w[sel];

  int total = 0, bad = 0;
  int done_cnt = 0;
  logic [0:127] pt_q[$], ins_q[$], exp_q[$];
  logic [0:127] c3[4], p3[4], ks[4], aad4[2], c3t, p3t, cur_h, cur_ej0;

  typedef struct {
    string name;
    int    kind;     // 0 = TC1, 1 = TC3, 2 = TC4
    bit    flip;
    int    dsel;
    int    dmax;
    bit    gaps;
    bit    restart;
    int    exp_npt;
    bit    exp_auth;
  } tc_t;
  tc_t tcs[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // AES stand-in: knows E_K for zero, J0 and the counter blocks of the active key.
  function automatic logic [0:127] aes_model(input logic [0:127] b);
    int idx;
    if (b == '0) return cur_h;
    if (b == {iv, 32'd1}) return cur_ej0;
    idx = int'(b[96:127]) - 2;
    if (b[0:95] == iv && idx >= 0 && idx < 4) return ks[idx];
    return '0;
  endfunction

  bit ack_sent = 0;
  int dly = 0;
  always @(negedge clk) begin
    aes_ack = 1'b0;
    if (!req_s) ack_sent = 0;
    else if (!ack_sent) begin
      if (dly == 0) begin
        aes_ack  = 1'b1;
        aes_res  = aes_model(blk_s);
        ack_sent = 1;
        dly      = (dmax > 0) ? $urandom_range(0, dmax) : 0;
      end else dly--;
    end
  end

  always @(negedge clk) begin
    if (ptv_s) pt_q.push_back(pt_s);
    if (done_s) done_cnt++;
  end

  task automatic launch(input int kind, input bit flip);
    ins_q.delete(); exp_q.delete(); pt_q.delete();
    if (kind == 0) begin
      cur_h    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      cur_ej0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
      iv       = '0;
      aad_size = 64'd0;
      ct_size  = 64'd0;
      tag      = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    end else begin
      cur_h   = 128'hb83b533708bf535d0aa6e52980d53b78;
      cur_ej0 = 128'h3247184b3c4f69a44dbcd22887bbb418;
      iv      = 96'hcafebabefacedbaddecaf888;
      if (kind == 1) begin
        aad_size = 64'd0;
        ct_size  = 64'd512;
        tag      = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
        for (int i = 0; i < 4; i++) begin
          ins_q.push_back(c3[i]);
          exp_q.push_back(p3[i]);
        end
      end else begin
        aad_size = 64'd160;
        ct_size  = 64'd480;
        tag      = 128'h5bc94fbc3221a5db94fae95ae7121a47;
        ins_q.push_back(aad4[0]);
        ins_q.push_back(aad4[1]);
        for (int i = 0; i < 3; i++) begin
          ins_q.push_back(c3[i]);
          exp_q.push_back(p3[i]);
        end
        ins_q.push_back(c3t);
        exp_q.push_back(p3t);
      end
    end
    if (flip) tag[127] = ~tag[127];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_block(input logic [0:127] b, input string nm);
    int t;
    valid = 1'b1;
    data  = b;
    t = 0;
    while (!ready_s && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) timeout_fail(nm);
    @(negedge clk);
    valid = 1'b0;
    data  = '0;
  endtask

  task automatic run_case(input tc_t tc);
    int nd0, t, n;
    sel  = tc.dsel;
    dmax = tc.dmax;
    nd0  = done_cnt;
    launch(tc.kind, tc.flip);
    chk({tc.name, "_auth_clr"}, auth_s, 0);
    for (int i = 0; i < ins_q.size(); i++) begin
      if (tc.gaps) repeat ($urandom_range(0, 4)) @(negedge clk);
      send_block(ins_q[i], {tc.name, "_ready"});
      // First AAD block is never the last one, so the gap after it is pure MULT.
      if (i == 0 && tc.kind == 2) begin
        n = 0;
        while (!ready_s && n < 1000) begin n++; @(negedge clk); end
        chk({tc.name, "_mult_len"}, n, (tc.dsel == 1) ? 16 : 128);
      end
      if (i == 0 && tc.restart) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == nd0 && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) timeout_fail({tc.name, "_done_wait"});
    chk({tc.name, "_auth"}, auth_s, tc.exp_auth);
    chk({tc.name, "_npt"}, pt_q.size(), tc.exp_npt);
    for (int i = 0; i < exp_q.size() && i < pt_q.size(); i++)
      chk($sformatf("%s_pt%0d", tc.name, i), pt_q[i], exp_q[i]);
    repeat (4) @(negedge clk);
    chk({tc.name, "_auth_hold"}, auth_s, tc.exp_auth);
    chk({tc.name, "_one_done"}, done_cnt - nd0, 1);
  endtask

  initial begin
    int nd0, t;
    c3[0] = 128'h42831ec2217774244b7221b784d0d49c;
    c3[1] = 128'he3aa212f2c02a4e035c17e2329aca12e;
    c3[2] = 128'h21d514b25466931c7d8f6a5aac84aa05;
    c3[3] = 128'h1ba30b396a0aac973d58e091473f5985;
    p3[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    p3[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    p3[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    p3[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    for (int i = 0; i < 4; i++) ks[i] = c3[i] ^ p3[i];
    aad4[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    aad4[1] = {32'habaddad2, 96'h123456789abcdef012345678};  // tail must be masked
    c3t     = {96'h1ba30b396a0aac973d58e091, 32'hdeadbeef};
    p3t     = {96'hb16aedf5aa0de657ba637b39, 32'h0};

    tcs[0] = '{"tc1",       0, 0, 0, 0,  0, 0, 0, 1};
    tcs[1] = '{"tc3",       1, 0, 0, 0,  0, 0, 4, 1};
    tcs[2] = '{"tc4",       2, 0, 0, 0,  0, 0, 4, 1};
    tcs[3] = '{"tc3_badtag",1, 1, 0, 0,  0, 0, 4, 0};
    tcs[4] = '{"tc4_d1_rnd",2, 0, 0, 20, 1, 0, 4, 1};
    tcs[5] = '{"tc4_d8_rnd",2, 0, 1, 20, 1, 0, 4, 1};
    tcs[6] = '{"tc3_d8_rst",1, 0, 1, 0,  0, 1, 4, 1};

    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; sel = 0; dmax = 0;
    iv = '0; tag = '0; aad_size = '0; ct_size = '0; aes_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_s, 0);
    chk("rst_req", req_s, 0);
    chk("rst_ptv", ptv_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_auth", auth_s, 0);
    chk("rst_pt", pt_s, 0);
    chk("rst_blk", blk_s, 0);
    chk("rst_ready8", ready_w[1], 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tcs[i]) run_case(tcs[i]);

    // Abort in the middle of CT_WAIT: no completion, then a clean rerun.
    sel = 0; dmax = 0;
    nd0 = done_cnt;
    launch(1, 0);
    send_block(ins_q[0], "abort_ready");
    t = 0;
    while (!ready_s && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) timeout_fail("abort_ready2");
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", ready_s, 0);
    chk("abort_req", req_s, 0);
    chk("abort_blk", blk_s, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("abort_no_done", done_cnt - nd0, 0);
    chk("abort_idle_ready", ready_s, 0);
    run_case(tcs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
